idli_sqi_ctrl_m: RTL

Sequencer for the external SQI (quad-SPI) SRAM and the 16b nibble-wide IO shift register.
- Issues the command, address and dummy phases.
- Gates the memory clock.
- Drives the IO register's write-enable and input source so that 16b words are filled from, or drained to, the SIO pins.
- Sits between the core's memory request logic and the chip pads; the IO register is instantiated alongside it.

---
 rtl/idli_pkg.sv | 30 +++
 rtl/idli_sqi_ctrl_m.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/idli_pkg.sv
// Shared types and constants for the SQI SRAM sequencer (idli_sqi_ctrl_m).
package idli_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CMD   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DUMMY = 3'd4,
        ST_DATA  = 3'd5,
        ST_DRAIN = 3'd6
    } sqi_state_t;

    localparam int CTR_W = 3;

    localparam logic [7:0] SQI_CMD_READ  = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

    // A 16b word is four nibbles, so LOAD/DATA/DRAIN all end on the same count.
    localparam logic [CTR_W-1:0] WORD_LAST = 3'd3;
    localparam logic [CTR_W-1:0] CMD_LAST  = 3'd1;

    // Command nibble for the given direction; hi selects the first (upper) nibble.
    function automatic logic [3:0] cmd_nibble(input logic wr, input logic hi);
        logic [7:0] cmd;
        cmd = wr ? SQI_CMD_WRITE : SQI_CMD_READ;
        return hi ? cmd[7:4] : cmd[3:0];
    endfunction

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// SQI (quad-SPI) SRAM sequencer: command/address/dummy phases, SCK gating and
// control of the external 16b nibble-wide IO shift register.
// Optional feature macro: IDLI_SQI_BURST_EN (word-boundary burst continuation).
//
// state | meaning
// IDLE  | cs_n high, waiting for a request
// LOAD  | shift four write nibbles from the core into the IO register
// CMD   | two command nibbles on SIO
// ADDR  | byte address nibbles on SIO, MSB first
// DUMMY | read turnaround, pads released
// DATA  | four data nibbles between IO register and SIO
// DRAIN | read word held in IO register for the core, SCK stopped
module idli_sqi_ctrl_m
    import idli_pkg::*;
#(
    parameter int ADDR_NIBBLES = 6,
    parameter int DUMMY_CYCLES = 2
) (
    input  logic        i_sqi_gck,
    input  logic        i_sqi_rst,
    input  logic        i_sqi_req,
    input  logic        i_sqi_wr,
    input  logic [15:0] i_sqi_addr,
    input  logic [3:0]  i_sqi_wdata,
    output logic        o_sqi_ack,
    output logic        o_sqi_rdata_vld,
    output logic        o_sqi_cs_n,
    output logic        o_sqi_sck_en,
    output logic [3:0]  o_sqi_sio,
    output logic        o_sqi_sio_oe,
    input  logic [3:0]  i_sqi_sio,
    output logic        o_sqi_reg_wr_en,
    output logic [3:0]  o_sqi_reg_data,
    input  logic [3:0]  i_sqi_reg_data
);

    localparam int AW = ADDR_NIBBLES * 4;
    localparam logic [CTR_W-1:0] ADDR_LAST  = CTR_W'(ADDR_NIBBLES - 1);
    localparam logic [CTR_W-1:0] DUMMY_LAST = CTR_W'((DUMMY_CYCLES == 0) ? 0 : DUMMY_CYCLES - 1);
    localparam bit HAS_DUMMY = (DUMMY_CYCLES != 0);

`ifdef IDLI_SQI_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    sqi_state_t         r_state;
    sqi_state_t         w_next;
    logic [CTR_W-1:0]   r_ctr;
    logic               r_wr;
    logic               r_cont;
    logic               r_ack;
    logic [AW-1:0]      r_addr_sh;
    logic [AW-1:0]      w_byte_addr;
    logic               w_accept;

    // Word address becomes a byte address with the unused upper bits zeroed.
    assign w_byte_addr = {{(AW - 17){1'b0}}, i_sqi_addr, 1'b0};
    assign w_accept    = (r_state == ST_IDLE) && i_sqi_req;

    // Next-state decode; the phase counter marks the last cycle of each phase.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_sqi_req) begin
                    w_next = i_sqi_wr ? ST_LOAD : ST_CMD;
                end
            end
            ST_LOAD: begin
                if (r_ctr == WORD_LAST) begin
                    w_next = r_cont ? ST_DATA : ST_CMD;
                end
            end
            ST_CMD: begin
                if (r_ctr == CMD_LAST) begin
                    w_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (r_ctr == ADDR_LAST) begin
                    if (!r_wr && HAS_DUMMY) begin
                        w_next = ST_DUMMY;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DUMMY: begin
                if (r_ctr == DUMMY_LAST) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_ctr == WORD_LAST) begin
                    if (!r_wr) begin
                        w_next = ST_DRAIN;
                    end else if (BURST_EN && i_sqi_req) begin
                        w_next = ST_LOAD;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_ctr == WORD_LAST) begin
                    w_next = (BURST_EN && i_sqi_req) ? ST_DATA : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, phase counter, captured request and address shifter.
    always_ff @(posedge i_sqi_gck) begin
        if (i_sqi_rst) begin
            r_state   <= ST_IDLE;
            r_ctr     <= '0;
            r_wr      <= 1'b0;
            r_cont    <= 1'b0;
            r_ack     <= 1'b0;
            r_addr_sh <= '0;
        end else begin
            r_state <= w_next;
            r_ctr   <= (w_next != r_state) ? '0 : r_ctr + 1'b1;
            r_ack   <= w_accept;
            if (w_accept) begin
                r_wr      <= i_sqi_wr;
                r_addr_sh <= w_byte_addr;
            end else if (r_state == ST_ADDR) begin
                r_addr_sh <= {r_addr_sh[AW-5:0], 4'h0};
            end
            // A LOAD entered from a DATA boundary keeps the chip selected.
            if (r_state == ST_IDLE) begin
                r_cont <= 1'b0;
            end else if (r_state == ST_DATA && w_next == ST_LOAD) begin
                r_cont <= 1'b1;
            end
        end
    end

    // Pad and IO-register controls decoded from the current state.
    always_comb begin
        o_sqi_cs_n      = 1'b1;
        o_sqi_sck_en    = 1'b0;
        o_sqi_sio       = 4'h0;
        o_sqi_sio_oe    = 1'b0;
        o_sqi_reg_wr_en = 1'b0;
        o_sqi_reg_data  = 4'h0;
        o_sqi_rdata_vld = 1'b0;
        case (r_state)
            ST_LOAD: begin
                o_sqi_cs_n      = ~r_cont;
                o_sqi_reg_wr_en = 1'b1;
                o_sqi_reg_data  = i_sqi_wdata;
            end
            ST_CMD: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
                o_sqi_sio_oe = 1'b1;
                o_sqi_sio    = cmd_nibble(r_wr, ~r_ctr[0]);
            end
            ST_ADDR: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
                o_sqi_sio_oe = 1'b1;
                o_sqi_sio    = r_addr_sh[AW-1 -: 4];
            end
            ST_DUMMY: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
            end
            ST_DATA: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
                if (r_wr) begin
                    o_sqi_sio_oe = 1'b1;
                    o_sqi_sio    = i_sqi_reg_data;
                end else begin
                    o_sqi_reg_wr_en = 1'b1;
                    o_sqi_reg_data  = i_sqi_sio;
                end
            end
            ST_DRAIN: begin
                o_sqi_cs_n      = 1'b0;
                o_sqi_rdata_vld = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_sqi_ack = r_ack;

endmodule
